// File: rtl/bypass_scoreboard_pkg.sv
// Shared types and constants for the bypass scoreboard (forwarding / load-use interlock unit).
// Tag value RNONE (register $zero) marks "no read" / "no write" and is never forwarded.
package bypass_scoreboard_pkg;

  localparam int unsigned RNONE     = 0;
  localparam int unsigned DefaultDw = 32;
  localparam int unsigned DefaultRw = 5;

  // Stage indices in the in-flight chain; stages beyond W are extra writeback slots.
  localparam int unsigned StageE = 0;
  localparam int unsigned StageM = 1;
  localparam int unsigned StageW = 2;

  // Per-port lookup result produced by the priority mux.
  typedef struct packed {
    logic hit;       // some in-flight entry matches the source tag
    logic loadUse;   // youngest match is the E entry and it is a load
    logic youngHit;  // youngest match has not yet reached the oldest stage
  } muxHit_t;

endpackage

// File: rtl/bypass_scoreboard_if.sv
// Decode-side bundle of the bypass scoreboard: decode request, live stage data and operand results.
// master = pipeline/decode side, slave = scoreboard.
interface bypass_scoreboard_if #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned DW     = 32,
  parameter int unsigned RW     = 5
);

  logic                 freeze;
  logic                 flush;
  logic                 d_valid;
  logic [RW-1:0]        d_dst;
  logic                 d_is_load;
  logic [NPORTS*RW-1:0] d_src;
  logic [NPORTS*DW-1:0] d_rval;
  logic [DW-1:0]        e_val;
  logic [DW-1:0]        m_ldval;
  logic [NPORTS*DW-1:0] d_val;
  logic                 stall;

  modport master (
    output freeze, flush, d_valid, d_dst, d_is_load, d_src, d_rval, e_val, m_ldval,
    input  d_val, stall
  );

  modport slave (
    input  freeze, flush, d_valid, d_dst, d_is_load, d_src, d_rval, e_val, m_ldval,
    output d_val, stall
  );

endinterface

// File: rtl/bypass_scoreboard_mux.sv
// Per-port priority select over the in-flight chain: youngest matching entry wins.
// Returns hit / load-use / not-yet-retired flags plus the matching stage value.
module bypass_scoreboard_mux
  import bypass_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned RW    = DefaultRw
) (
  input  logic [RW-1:0]    src,
  input  logic [DEPTH-1:0] vld,
  input  logic [RW-1:0]    dst  [DEPTH],
  input  logic             eLd,
  input  logic [DW-1:0]    vals [DEPTH],
  output muxHit_t          res,
  output logic [DW-1:0]    val
);

  always_comb begin
    res = '0;
    val = '0;
    // Scan oldest to youngest so a younger match overrides any older duplicate.
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (src != RW'(RNONE) && vld[k] && dst[k] == src) begin
        res.hit      = 1'b1;
        res.loadUse  = (k == 0) && eLd;
        res.youngHit = (k != int'(DEPTH) - 1);
        val          = vals[k];
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// Operand-forwarding and load-use interlock unit: in-flight write chain (E, M, W, ...) plus
// per-port forwarding. Define FWD_BYPASS_EN for full forwarding; otherwise interlock-only.
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned DW     = DefaultDw,
  parameter int unsigned RW     = DefaultRw
) (
  input logic                clk,
  input logic                rst,
  bypass_scoreboard_if.slave bus
);

  logic [DEPTH-1:0]            vld_q;
  logic [RW-1:0]               dst_q [DEPTH];
  logic                        ldE_q;
  logic [DW-1:0]               stageVal [DEPTH];
  muxHit_t [NPORTS-1:0]        portHit;
  logic [NPORTS-1:0]           hitVec;
  logic [NPORTS-1:0]           loadUseVec;
  logic [NPORTS-1:0]           youngVec;
  logic [NPORTS-1:0][DW-1:0]   fwdVal;
  logic                        stall;
  logic                        issue;
  logic                        unusedSig;

  assign issue     = bus.d_valid & ~stall & ~bus.flush;
  assign bus.stall = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      ldE_q <= 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) dst_q[k] <= '0;
    end else if (!bus.freeze) begin
      vld_q    <= {vld_q[DEPTH-2:0], issue};
      dst_q[0] <= bus.d_dst;
      for (int k = 1; k < int'(DEPTH); k++) dst_q[k] <= dst_q[k-1];
      ldE_q    <= bus.d_is_load;
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : gPort
    bypass_scoreboard_mux #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .RW    (RW)
    ) uMux (
      .src  (bus.d_src[p*RW +: RW]),
      .vld  (vld_q),
      .dst  (dst_q),
      .eLd  (ldE_q),
      .vals (stageVal),
      .res  (portHit[p]),
      .val  (fwdVal[p])
    );
    assign hitVec[p]     = portHit[p].hit;
    assign loadUseVec[p] = portHit[p].loadUse;
    assign youngVec[p]   = portHit[p].youngHit;
  end

`ifdef FWD_BYPASS_EN
  logic              ldM_q;
  logic [DW-1:0]     val_q [1:DEPTH-1];
  logic [DW-1:0]     mVal;

  // A load's data only exists live in M; it is captured as it moves into W.
  assign mVal = ldM_q ? bus.m_ldval : val_q[StageM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldM_q <= 1'b0;
      for (int k = 1; k < int'(DEPTH); k++) val_q[k] <= '0;
    end else if (!bus.freeze) begin
      ldM_q         <= ldE_q;
      val_q[StageM] <= bus.e_val;
      val_q[StageW] <= mVal;
      for (int k = 3; k < int'(DEPTH); k++) val_q[k] <= val_q[k-1];
    end
  end

  always_comb begin
    stageVal[StageE] = bus.e_val;
    stageVal[StageM] = mVal;
    for (int k = 2; k < int'(DEPTH); k++) stageVal[k] = val_q[k];
  end

  assign stall = |loadUseVec;

  always_comb begin
    bus.d_val = bus.d_rval;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (hitVec[p]) bus.d_val[p*DW +: DW] = fwdVal[p];
    end
  end

  assign unusedSig = ^youngVec;
`else
  // Interlock-only: wait until the writer reaches the oldest stage (register file written).
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) stageVal[k] = '0;
  end

  assign stall     = |youngVec;
  assign bus.d_val = bus.d_rval;
  assign unusedSig = ^{hitVec, loadUseVec, fwdVal, bus.e_val, bus.m_ldval};
`endif

endmodule
